// File: rtl/ibex_mem_resp_pkg.sv
// Shared types and parameter-legality helpers for the Ibex memory responder.
package ibex_mem_resp_pkg;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } mem_resp_t;

   function automatic bit mem_size_ok(input int unsigned words);
      return (words != 0) && ((words & (words - 1)) == 0);
   endfunction

   function automatic bit base_aligned(input logic [31:0] base, input int unsigned words);
      return (base % (32'd4 * words)) == 32'd0;
   endfunction

   function automatic bit latency_ok(input int unsigned lat);
      return (lat >= 1) && (lat <= 4);
   endfunction

   function automatic bit max_outstanding_ok(input int unsigned mo);
      return (mo >= 1) && (mo <= 4);
   endfunction

endpackage

// File: rtl/ibex_mem_resp_pipe.sv
// Latency-stage valid/response delay line; stages carry zero data when empty so idle outputs read 0.
module ibex_mem_resp_pipe
   import ibex_mem_resp_pkg::*;
#(
   parameter int unsigned Latency = 1
) (
   input  logic      i_clk,
   input  logic      i_rst_n,
   input  logic      i_vld,
   input  mem_resp_t i_dat,
   output logic      o_vld,
   output mem_resp_t o_dat
);
   logic [Latency-1:0] r_vld;
   mem_resp_t          r_dat [Latency];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld <= '0;
         for (int i = 0; i < int'(Latency); i++) r_dat[i] <= '0;
      end else begin
         r_vld[0] <= i_vld;
         r_dat[0] <= i_vld ? i_dat : '0;
         for (int i = 1; i < int'(Latency); i++) begin
            r_vld[i] <= r_vld[i-1];
            r_dat[i] <= r_dat[i-1];
         end
      end
   end

   assign o_vld = r_vld[Latency-1];
   assign o_dat = r_dat[Latency-1];
endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted SECDED (39,32) encoder: data passes through in [31:0], check bits in [38:32].
module prim_secded_inv_39_32_enc (
   input  logic [31:0] data_i,
   output logic [38:0] data_o
);
   always_comb begin
      data_o     = {7'b0, data_i};
      data_o[32] = ^(data_i & 32'h2606BD25);
      data_o[33] = ^(data_i & 32'hDEBA8050);
      data_o[34] = ^(data_i & 32'h413D89AA);
      data_o[35] = ^(data_i & 32'h31234ED1);
      data_o[36] = ^(data_i & 32'hC2C1323B);
      data_o[37] = ^(data_i & 32'h2DCC624C);
      data_o[38] = ^(data_i & 32'h98505586);
      data_o     = data_o ^ 39'h2A_0000_0000;
   end
endmodule

// File: rtl/ibex_mem_responder.sv
// Single-port memory responder on the Ibex req/gnt/rvalid bus: word reads, byte-enabled writes,
// fixed-latency in-order responses with SECDED read integrity and write-integrity checking.
module ibex_mem_responder
   import ibex_mem_resp_pkg::*;
#(
   parameter int unsigned MemSizeWords   = 1024,
   parameter logic [31:0] BaseAddr       = 32'h0010_0000,
   parameter int unsigned Latency        = 1,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [6:0]  wdata_intg_i,
   input  logic        stall_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic [6:0]  rdata_intg_o,
   output logic        err_o,
   output logic        intg_err_o
);
   localparam int unsigned IdxW = $clog2(MemSizeWords);

   if (!mem_size_ok(MemSizeWords)) begin : g_bad_size
      $error("MemSizeWords must be a power of two");
   end
   if (!base_aligned(BaseAddr, MemSizeWords)) begin : g_bad_base
      $error("BaseAddr must be aligned to the array size in bytes");
   end
   if (!latency_ok(Latency)) begin : g_bad_lat
      $error("Latency must be in 1..4");
   end
   if (!max_outstanding_ok(MaxOutstanding)) begin : g_bad_mo
      $error("MaxOutstanding must be in 1..4");
   end

   logic [31:0]     r_mem [MemSizeWords];
   logic [2:0]      r_outst;
   logic            r_intg_err;
   logic [2:0]      w_outst_eff;
   logic            w_in_range;
   logic            w_intg_bad;
   logic            w_wr_ok;
   logic [IdxW-1:0] w_idx;
   logic [38:0]     w_wenc;
   logic [38:0]     w_renc;
   mem_resp_t       w_resp;
   mem_resp_t       w_out;
   logic            w_out_vld;

   // A response leaving this cycle frees its slot for a same-cycle grant.
   assign w_outst_eff = r_outst - {2'b0, w_out_vld};
   assign gnt_o       = rst_ni & req_i & ~stall_i & (w_outst_eff < 3'(MaxOutstanding));

   assign w_in_range = (addr_i >= BaseAddr) &&
                       ({1'b0, addr_i} < ({1'b0, BaseAddr} + 33'(32'd4 * MemSizeWords)));
   assign w_idx      = addr_i[2 +: IdxW];

   prim_secded_inv_39_32_enc u_wenc (.data_i(wdata_i), .data_o(w_wenc));
   assign w_intg_bad = (w_wenc != {wdata_intg_i, wdata_i});
   assign w_wr_ok    = gnt_o & we_i & w_in_range & ~w_intg_bad;

   always_ff @(posedge clk_i) begin
      if (w_wr_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   always_comb begin
      w_resp = '0;
      if (!w_in_range || (we_i && w_intg_bad)) w_resp.err = 1'b1;
      else if (!we_i)                          w_resp.rdata = r_mem[w_idx];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_outst    <= '0;
         r_intg_err <= 1'b0;
      end else begin
         r_outst    <= r_outst + {2'b0, gnt_o} - {2'b0, w_out_vld};
         r_intg_err <= gnt_o & we_i & w_intg_bad;
      end
   end

   ibex_mem_resp_pipe #(.Latency(Latency)) u_pipe (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_vld   (gnt_o),
      .i_dat   (w_resp),
      .o_vld   (w_out_vld),
      .o_dat   (w_out)
   );

   prim_secded_inv_39_32_enc u_renc (.data_i(w_out.rdata), .data_o(w_renc));

   assign rvalid_o     = w_out_vld;
   assign err_o        = w_out.err;
   assign rdata_o      = w_renc[31:0];
   assign rdata_intg_o = w_renc[38:32];
   assign intg_err_o   = r_intg_err;
endmodule

// File: tb/tb_ibex_mem_responder.sv
// Directed + random bench for ibex_mem_responder against a transaction-level reference model.
module tb_ibex_mem_responder;
   localparam int          L    = 3;
   localparam int          MO   = 2;
   localparam int          MSW  = 1024;
   localparam logic [31:0] BASE = 32'h0010_0000;

   logic        clk_i = 1'b0, rst_ni = 1'b0, req_i = 1'b0, we_i = 1'b0, stall_i = 1'b0;
   logic [3:0]  be_i = 4'h0;
   logic [31:0] addr_i = '0, wdata_i = '0;
   logic [6:0]  wdata_intg_i = '0;
   logic        gnt_o, rvalid_o, err_o, intg_err_o;
   logic [31:0] rdata_o;
   logic [6:0]  rdata_intg_o;

   ibex_mem_responder #(.MemSizeWords(MSW), .BaseAddr(BASE), .Latency(L), .MaxOutstanding(MO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .be_i(be_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .wdata_intg_i(wdata_intg_i), .stall_i(stall_i),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rdata_intg_o(rdata_intg_o), .err_o(err_o),
      .intg_err_o(intg_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mem_m [int];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic        pend_intg = 1'b0;
   logic        last_gnt = 1'b0;

   function automatic logic [6:0] ref_intg(input logic [31:0] d);
      logic [31:0] m [7];
      logic [6:0]  c;
      m = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
            32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
      for (int i = 0; i < 7; i++) c[i] = ^(d & m[i]);
      return c ^ 7'h2A;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // One bus cycle: inputs already driven just after the edge; sample mid-cycle, advance the model.
   task automatic cycle();
      logic        exp_rv, exp_gnt, inr, bad;
      logic [31:0] exp_data, cur;
      logic        exp_err;
      int          outst, idx;
      #4;
      if (!rst_ni) begin
         q.delete();
         pend_intg = 1'b0;
      end
      exp_rv   = (q.size() > 0) && (q[0].due == cyc);
      exp_err  = exp_rv ? q[0].err : 1'b0;
      exp_data = exp_rv ? q[0].data : 32'h0;
      outst    = q.size() - (exp_rv ? 1 : 0);
      exp_gnt  = rst_ni && req_i && !stall_i && (outst < MO);
      check("gnt", gnt_o, exp_gnt);
      check("rvalid", rvalid_o, exp_rv);
      check("err", err_o, exp_err);
      check("rdata", rdata_o, exp_data);
      check("rdata_intg", rdata_intg_o, ref_intg(exp_data));
      check("intg_err", intg_err_o, pend_intg);
      last_gnt  = gnt_o;
      pend_intg = 1'b0;
      if (exp_rv) void'(q.pop_front());
      if (exp_gnt) begin
         inr = (addr_i >= BASE) && (addr_i < BASE + 32'(4 * MSW));
         idx = int'((addr_i - BASE) >> 2);
         bad = we_i && (wdata_intg_i != ref_intg(wdata_i));
         if (bad) pend_intg = 1'b1;
         if (!inr || bad) begin
            q.push_back('{cyc + L, 1'b1, 32'h0});
         end else if (we_i) begin
            cur = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            for (int b = 0; b < 4; b++) if (be_i[b]) cur[8*b +: 8] = wdata_i[8*b +: 8];
            mem_m[idx] = cur;
            q.push_back('{cyc + L, 1'b0, 32'h0});
         end else begin
            q.push_back('{cyc + L, 1'b0, mem_m[idx]});
         end
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      req_i = 1'b0;
      stall_i = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Present one request, holding it until granted; stall_cycles forces back-pressure first.
   task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic flip, input int stall_cycles);
      int guard = 0;
      req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
      wdata_intg_i = ref_intg(wdata) ^ (flip ? 7'h04 : 7'h00);
      do begin
         stall_i = (guard < stall_cycles);
         cycle();
         guard++;
      end while (!last_gnt && guard < 20);
      check("grant_timeout", last_gnt, 1'b1);
      req_i = 1'b0;
      stall_i = 1'b0;
   endtask

   initial begin
      logic [7:0] pat;
      int         nxt;
      logic [31:0] a;
      @(posedge clk_i);
      #1;
      for (int i = 0; i < 3; i++) cycle();  // reset values
      rst_ni = 1'b1;
      idle(1);

      for (int i = 0; i < 16; i++)
         issue(1'b1, 4'hF, BASE + 32'(4 * i), 32'hA500_0000 ^ (32'h0101_0101 * i), 1'b0, 0);
      idle(L + 1);

      issue(1'b1, 4'hF, 32'h0010_0010, 32'hDEAD_BEEF, 1'b0, 0);
      issue(1'b0, 4'hF, 32'h0010_0010, 32'h0, 1'b0, 0);
      idle(L + 1);

      issue(1'b1, 4'hF, 32'h0010_0020, 32'h1122_3344, 1'b0, 0);
      issue(1'b1, 4'b0101, 32'h0010_0020, 32'hAABB_CCDD, 1'b0, 0);
      issue(1'b0, 4'hF, 32'h0010_0020, 32'h0, 1'b0, 0);
      idle(L + 1);

      issue(1'b0, 4'hF, 32'h0010_1000, 32'h0, 1'b0, 0);
      issue(1'b0, 4'hF, 32'h000F_FFFC, 32'h0, 1'b0, 0);
      issue(1'b1, 4'hF, 32'h0010_1004, 32'h1234_5678, 1'b0, 0);
      idle(L + 1);

      issue(1'b1, 4'hF, 32'h0010_0024, 32'h0BAD_F00D, 1'b1, 0);
      issue(1'b0, 4'hF, 32'h0010_0024, 32'h0, 1'b0, 0);
      issue(1'b1, 4'h0, 32'h0010_0028, 32'hFFFF_FFFF, 1'b0, 0);
      issue(1'b0, 4'hF, 32'h0010_0028, 32'h0, 1'b0, 0);
      idle(L + 1);

      issue(1'b0, 4'hF, 32'h0010_0004, 32'h0, 1'b0, 3);
      idle(L + 1);

      nxt = 0;
      pat = '0;
      req_i = 1'b1; we_i = 1'b0; be_i = 4'hF;
      for (int k = 0; k < 8; k++) begin
         addr_i = BASE + 32'(4 * nxt);
         cycle();
         pat[7-k] = last_gnt;
         if (last_gnt) nxt++;
      end
      req_i = 1'b0;
      check("throttle_pattern", pat, 8'b1101_1011);
      idle(L + 1);

      req_i = 1'b1; we_i = 1'b0; addr_i = BASE + 32'd4;
      cycle();
      addr_i = BASE + 32'd8;
      cycle();
      req_i = 1'b0;
      rst_ni = 1'b0;
      cycle();
      cycle();
      rst_ni = 1'b1;
      idle(L + 3);

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 9))
            0:       a = BASE + 32'(4 * MSW) + 32'(4 * $urandom_range(0, 15));
            1:       a = BASE - 32'd4;
            default: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         endcase
         issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0) ? 2 : 0);
         if ($urandom_range(0, 4) == 0) idle(1);
      end
      idle(L + 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
